// File: rtl/ysyx_22040759_axi_arb.sv
// ----------------------------------------------------------------------------
// ysyx_22040759_axi_arb
//
// Arbitrates three CPU-side memory requesters onto one AXI master pair. The
// requesters are instruction fetch (IF, read), data load (LD, read) and data
// store (ST, write). Only one transaction is outstanding at a time.
//
// When a requester is granted, the arbiter latches its address, size and
// (for stores) data into held registers. It then sends a one-cycle start
// pulse to the read or write master. When that master reports completion,
// the arbiter returns a one-cycle ack, plus the read data, to the granted
// requester.
//
// Arbitration priority is ST > LD > IF. The exception is that IF wins once
// after STARVE_MAX consecutive LD/ST grants have been made while IF was
// waiting.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   if_req_i/addr_i     IF read request (level) and address
//   if_ack_o/rdata_o    IF completion pulse and read data
//   ld_req_i/addr_i/size_i   load request, address, AXI size
//   ld_ack_o/rdata_o    load completion pulse and read data
//   st_req_i/addr_i/size_i/wdata_i   store request, address, size, data
//   st_ack_o            store completion pulse
//   rd_start_o          one-cycle start pulse to the read master
//   rd_addr_o/size_o    held read address and size
//   rd_done_i/data_i    read master completion and read data
//   wr_addr_valid_o     one-cycle start pulse to the write master
//   wr_addr_o/size_o/data_o  held write address, size and data
//   wr_data_valid_i     write master completion (B handshake)
// ----------------------------------------------------------------------------
module ysyx_22040759_axi_arb #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,

    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [2:0]        ld_size_i,
    output logic              ld_ack_o,
    output logic [DATA_W-1:0] ld_rdata_o,

    input  logic              st_req_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [2:0]        st_size_i,
    input  logic [DATA_W-1:0] st_wdata_i,
    output logic              st_ack_o,

    output logic              rd_start_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [2:0]        rd_size_o,
    input  logic              rd_done_i,
    input  logic [DATA_W-1:0] rd_data_i,

    output logic              wr_addr_valid_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [2:0]        wr_size_o,
    output logic [DATA_W-1:0] wr_data_o,
    input  logic              wr_data_valid_i
);

    localparam int          CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [2:0]  IF_SIZE = 3'b010;  // instruction fetch is always 32-bit

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LD_RD = 2'd2,
        ST_WR = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  starve_cnt;

    logic              grant_if;
    logic              grant_ld;
    logic              grant_st;
    logic              grant_any;
    logic              ack_cycle;
    logic              starve_hit;

    logic              rd_start_d;
    logic              wr_start_d;
    logic              if_ack_d;
    logic              ld_ack_d;
    logic              st_ack_d;

    logic [ADDR_W-1:0] hold_addr;
    logic [2:0]        hold_size;
    logic [DATA_W-1:0] hold_wdata;

    // The ack cycle is spent in IDLE without granting. This gives the
    // requester one cycle to drop its request before it is arbitrated again.
    assign ack_cycle  = if_ack_o | ld_ack_o | st_ack_o;
    assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX)) && if_req_i;
    assign grant_any  = grant_if | grant_ld | grant_st;

    always_comb begin : arbitrate
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        grant_if = 1'b0;
        grant_ld = 1'b0;
        grant_st = 1'b0;
        if (state == IDLE && !ack_cycle) begin
            if (starve_hit) begin
                grant_if = 1'b1;
            end else if (st_req_i) begin
                grant_st = 1'b1;
            end else if (ld_req_i) begin
                grant_ld = 1'b1;
            end else if (if_req_i) begin
                grant_if = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin : state_reg
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples values from before the edge, independent of
        // statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A completion on the channel that does not belong to
    // the current state falls through and is ignored.
    always_comb begin : next_state
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_st)      state_nxt = ST_WR;
                else if (grant_ld) state_nxt = LD_RD;
                else if (grant_if) state_nxt = IF_RD;
            end
            IF_RD, LD_RD: if (rd_done_i)       state_nxt = IDLE;
            ST_WR:        if (wr_data_valid_i) state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    // Output decode. These values are registered below, so each pulse
    // appears one cycle after the event that caused it.
    always_comb begin : output_decode
        rd_start_d = grant_if | grant_ld;
        wr_start_d = grant_st;
        if_ack_d   = (state == IF_RD) && rd_done_i;
        ld_ack_d   = (state == LD_RD) && rd_done_i;
        st_ack_d   = (state == ST_WR) && wr_data_valid_i;
    end

    always_ff @(posedge clk) begin : output_regs
        if (rst) begin
            rd_start_o      <= 1'b0;
            wr_addr_valid_o <= 1'b0;
            if_ack_o        <= 1'b0;
            ld_ack_o        <= 1'b0;
            st_ack_o        <= 1'b0;
            if_rdata_o      <= '0;
            ld_rdata_o      <= '0;
        end else begin
            rd_start_o      <= rd_start_d;
            wr_addr_valid_o <= wr_start_d;
            if_ack_o        <= if_ack_d;
            ld_ack_o        <= ld_ack_d;
            st_ack_o        <= st_ack_d;
            if (if_ack_d) if_rdata_o <= rd_data_i;
            if (ld_ack_d) ld_rdata_o <= rd_data_i;
        end
    end

    // Held request registers. They are written only on a grant, so changes
    // on the requester inputs during a transaction never reach the masters.
    always_ff @(posedge clk) begin : hold_regs
        if (rst) begin
            hold_addr  <= '0;
            hold_size  <= '0;
            hold_wdata <= '0;
        end else if (grant_st) begin
            hold_addr  <= st_addr_i;
            hold_size  <= st_size_i;
            hold_wdata <= st_wdata_i;
        end else if (grant_ld) begin
            hold_addr  <= ld_addr_i;
            hold_size  <= ld_size_i;
        end else if (grant_if) begin
            hold_addr  <= if_addr_i;
            hold_size  <= IF_SIZE;
        end
    end

    // The starve counter tracks consecutive LD/ST grants made while IF was
    // waiting. It saturates at STARVE_MAX. It clears when IF is granted, or
    // when any grant is made while IF is not requesting.
    always_ff @(posedge clk) begin : starve_reg
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_any) begin
            if (grant_if || !if_req_i) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    assign rd_addr_o = hold_addr;
    assign rd_size_o = hold_size;
    assign wr_addr_o = hold_addr;
    assign wr_size_o = hold_size;
    assign wr_data_o = hold_wdata;

endmodule

// File: tb/tb_ysyx_22040759_axi_arb.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22040759_axi_arb
//
// Self-checking bench for ysyx_22040759_axi_arb.
//
// The bench plays two roles. It acts as the three requesters, holding a set
// of pending requests. It also acts as the downstream read and write
// masters, completing each transaction after a chosen latency.
//
// A transaction-level model picks the expected winner of each arbitration
// from the pending set and a starve count. Each transaction is checked for:
//   - the start pulse on the correct channel;
//   - held address, size and data that stay stable while busy;
//   - the ack reaching only the owner, with the correct read data;
//   - no new grant during the ack cycle.
//
// Directed steps come first, followed by randomized traffic.
// ----------------------------------------------------------------------------
module tb_ysyx_22040759_axi_arb;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int STARVE_MAX = 4;
    localparam int W_IF = 0;
    localparam int W_LD = 1;
    localparam int W_ST = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_i, ld_req_i, st_req_i;
    logic [ADDR_W-1:0] if_addr_i, ld_addr_i, st_addr_i;
    logic [2:0]        ld_size_i, st_size_i;
    logic [DATA_W-1:0] st_wdata_i;
    logic              if_ack_o, ld_ack_o, st_ack_o;
    logic [DATA_W-1:0] if_rdata_o, ld_rdata_o;
    logic              rd_start_o, rd_done_i;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [2:0]        rd_size_o;
    logic [DATA_W-1:0] rd_data_i;
    logic              wr_addr_valid_o, wr_data_valid_i;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [2:0]        wr_size_o;
    logic [DATA_W-1:0] wr_data_o;

    always #5 clk = ~clk;

    ysyx_22040759_axi_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_size_i(ld_size_i),
        .ld_ack_o(ld_ack_o), .ld_rdata_o(ld_rdata_o),
        .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_size_i(st_size_i),
        .st_wdata_i(st_wdata_i), .st_ack_o(st_ack_o),
        .rd_start_o(rd_start_o), .rd_addr_o(rd_addr_o), .rd_size_o(rd_size_o),
        .rd_done_i(rd_done_i), .rd_data_i(rd_data_i),
        .wr_addr_valid_o(wr_addr_valid_o), .wr_addr_o(wr_addr_o),
        .wr_size_o(wr_size_o), .wr_data_o(wr_data_o),
        .wr_data_valid_i(wr_data_valid_i)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Requester-side model: pending flags and request contents per requester,
    // plus the count of consecutive LD/ST grants made while IF waited.
    bit   [2:0]  p;
    logic [63:0] r_addr [3];
    logic [2:0]  r_size [3];
    logic [63:0] st_data;
    int          m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        if_req_i   = p[W_IF];
        if_addr_i  = r_addr[W_IF];
        ld_req_i   = p[W_LD];
        ld_addr_i  = r_addr[W_LD];
        ld_size_i  = r_size[W_LD];
        st_req_i   = p[W_ST];
        st_addr_i  = r_addr[W_ST];
        st_size_i  = r_size[W_ST];
        st_wdata_i = st_data;
    endtask

    task automatic set_req(input int k, input logic [63:0] a, input logic [2:0] s,
                           input logic [63:0] d);
        p[k]      = 1'b1;
        r_addr[k] = a;
        r_size[k] = s;
        if (k == W_ST) st_data = d;
    endtask

    // Expected winner: ST over LD over IF, unless IF has waited through
    // STARVE_MAX consecutive LD/ST grants.
    function automatic int pick();
        if (m_cnt == STARVE_MAX && p[W_IF]) return W_IF;
        if (p[W_ST]) return W_ST;
        if (p[W_LD]) return W_LD;
        return W_IF;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pulse"}, 64'({rd_start_o, wr_addr_valid_o}), 64'd0);
        check({tag, "_ack"}, 64'({if_ack_o, ld_ack_o, st_ack_o}), 64'd0);
    endtask

    // Runs one transaction from grant to the end of the ack cycle.
    //   exp_w : the expected winner, or -1 to let the model pick it.
    //   lat   : the number of busy cycles before completion.
    //   spur  : if set, the other channel signals completion while busy,
    //           and the owner's address input is scrambled meanwhile.
    //   data  : the read data returned by the read master.
    task automatic run_txn(input int exp_w, input int lat, input bit spur,
                           input logic [63:0] data);
        int          w;
        logic [63:0] a;
        logic [2:0]  sz;
        w  = (exp_w >= 0) ? exp_w : pick();
        a  = r_addr[w];
        sz = (w == W_IF) ? 3'd2 : r_size[w];
        if (w == W_IF || !p[W_IF]) m_cnt = 0;
        else if (m_cnt < STARVE_MAX) m_cnt++;

        drive();
        tick();
        check("start_rd", 64'(rd_start_o), 64'(w != W_ST));
        check("start_wr", 64'(wr_addr_valid_o), 64'(w == W_ST));
        check("grant_addr", (w == W_ST) ? wr_addr_o : rd_addr_o, a);
        check("grant_size", 64'((w == W_ST) ? wr_size_o : rd_size_o), 64'(sz));
        if (w == W_ST) check("grant_wdata", wr_data_o, st_data);

        for (int i = 0; i < lat; i++) begin
            if (spur) begin
                if (w == W_ST) rd_done_i = 1'b1;
                else           wr_data_valid_i = 1'b1;
                case (w)
                    W_IF:    if_addr_i = {$urandom, $urandom};
                    W_LD:    ld_addr_i = {$urandom, $urandom};
                    default: st_addr_i = {$urandom, $urandom};
                endcase
            end
            tick();
            rd_done_i       = 1'b0;
            wr_data_valid_i = 1'b0;
            check_idle_outputs("busy");
            check("busy_addr", (w == W_ST) ? wr_addr_o : rd_addr_o, a);
            check("busy_size", 64'((w == W_ST) ? wr_size_o : rd_size_o), 64'(sz));
            if (w == W_ST) check("busy_wdata", wr_data_o, st_data);
        end

        if (w == W_ST) begin
            wr_data_valid_i = 1'b1;
        end else begin
            rd_done_i = 1'b1;
            rd_data_i = data;
        end
        tick();
        rd_done_i       = 1'b0;
        wr_data_valid_i = 1'b0;
        rd_data_i       = {$urandom, $urandom};
        check("ack_owner", 64'({if_ack_o, ld_ack_o, st_ack_o}), 64'(3'b100 >> w));
        if (w == W_IF) check("if_rdata", if_rdata_o, data);
        if (w == W_LD) check("ld_rdata", ld_rdata_o, data);

        // The request is still high through the ack cycle, so no grant may follow.
        tick();
        check_idle_outputs("ack_gap");
        p[w] = 1'b0;
        drive();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pulses"}, 64'({rd_start_o, wr_addr_valid_o, if_ack_o, ld_ack_o, st_ack_o}), 64'd0);
        check({tag, "_rd_addr"}, rd_addr_o, 64'd0);
        check({tag, "_rd_size"}, 64'(rd_size_o), 64'd0);
        check({tag, "_wr_addr"}, wr_addr_o, 64'd0);
        check({tag, "_wr_size"}, 64'(wr_size_o), 64'd0);
        check({tag, "_wr_data"}, wr_data_o, 64'd0);
        check({tag, "_rdata"}, 64'(if_rdata_o | ld_rdata_o), 64'd0);
    endtask

    initial begin
        p               = '0;
        r_addr          = '{default: '0};
        r_size          = '{default: '0};
        st_data         = '0;
        m_cnt           = 0;
        rd_done_i       = 1'b0;
        rd_data_i       = '0;
        wr_data_valid_i = 1'b0;
        drive();

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single IF fetch: read size forced to 2, data returned after 3 cycles
        set_req(W_IF, 64'h8000_0000, 3'd7, '0);
        run_txn(W_IF, 3, 1'b0, 64'h13);

        // Store held until completion, with no re-grant in the ack cycle
        set_req(W_ST, 64'h8000_0104, 3'd0, 64'hAB);
        run_txn(W_ST, 3, 1'b0, '0);

        // All three requesters at once: ST, then LD, then IF
        set_req(W_IF, 64'h8000_1000, 3'd0, '0);
        set_req(W_LD, 64'h8000_2008, 3'd3, '0);
        set_req(W_ST, 64'h8000_3010, 3'd1, 64'h1122_3344_5566_7788);
        run_txn(W_ST, 1, 1'b0, '0);
        run_txn(W_LD, 0, 1'b0, 64'hDEAD_BEEF_0000_0001);
        run_txn(W_IF, 2, 1'b0, 64'h0000_0000_0000_0093);

        // LD and IF requested continuously: four LD grants, then one IF grant
        for (int k = 0; k < 10; k++) begin
            set_req(W_IF, 64'h8000_0400 + 64'(k * 4), 3'd0, '0);
            set_req(W_LD, 64'h9000_0000 + 64'(k * 8), 3'd3, '0);
            run_txn((k % 5 == 4) ? W_IF : W_LD, 1, 1'b0, 64'(k + 64'h100));
        end
        p = '0;
        drive();

        // Spurious completions in IDLE produce no ack and no grant
        rd_done_i = 1'b1;
        rd_data_i = 64'hBAD;
        tick();
        rd_done_i       = 1'b0;
        wr_data_valid_i = 1'b1;
        check_idle_outputs("idle_spur_rd");
        tick();
        wr_data_valid_i = 1'b0;
        check_idle_outputs("idle_spur_wr");
        tick();
        check_idle_outputs("idle_spur_after");

        // A write completion during LD_RD is ignored
        set_req(W_LD, 64'h8000_0500, 3'd2, '0);
        run_txn(W_LD, 2, 1'b1, 64'h5555_AAAA_5555_AAAA);

        // Reset mid ST_WR: back to IDLE with all outputs 0 and no ack
        set_req(W_ST, 64'h8000_0600, 3'd3, 64'hFEED_F00D);
        drive();
        tick();
        check("rst_pre_start", 64'(wr_addr_valid_o), 64'd1);
        tick();
        p = '0;
        drive();
        rst             = 1'b1;
        wr_data_valid_i = 1'b1;
        tick();
        rst             = 1'b0;
        wr_data_valid_i = 1'b0;
        m_cnt           = 0;
        check_reset_outputs("mid_rst");
        tick();
        check_idle_outputs("post_rst");
        set_req(W_IF, 64'h8000_0700, 3'd0, '0);
        run_txn(W_IF, 1, 1'b0, 64'h0000_0013_0000_0013);

        // Randomized traffic checked against the model
        for (int t = 0; t < 60; t++) begin
            for (int k = 0; k < 3; k++) begin
                if (!p[k] && $urandom_range(0, 1) == 1)
                    set_req(k, {$urandom, $urandom}, 3'($urandom_range(0, 3)), {$urandom, $urandom});
            end
            if (p == '0)
                set_req(int'($urandom_range(0, 2)), {$urandom, $urandom},
                        3'($urandom_range(0, 3)), {$urandom, $urandom});
            run_txn(-1, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                    {$urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
